// File: rtl/phase_pkg.sv
// Shared types, constants and helpers for the phase_average block.
//   fp_t      : 32-bit signed fixed point, 8 fractional bits.
//   wrap_deg  : folds an angle difference into (-180, 180] degrees.
//   state_e   : phase_average FSM states.
package phase_pkg;

  typedef logic signed [31:0] fp_t;

  localparam int FP_FRAC_BITS = 8;
  localparam int DEG180_FP    = 180 << FP_FRAC_BITS;  // 46080
  localparam int DEG360_FP    = 360 << FP_FRAC_BITS;  // 92160

  typedef enum logic [1:0] {IDLE, COLLECT, DIV, WRAP} state_e;

  // Inputs are differences of two in-range angles, so one fold is enough.
  function automatic fp_t wrap_deg(input logic signed [33:0] x);
    logic signed [33:0] y;
    y = x;
    if (x > 34'(DEG180_FP)) begin
      y = x - 34'(DEG360_FP);
    end else if (x <= -34'(DEG180_FP)) begin
      y = x + 34'(DEG360_FP);
    end
    return y[31:0];
  endfunction

endpackage

// File: rtl/seq_div_s.sv
// Signed restoring divider, truncating toward zero, fixed 32-cycle latency.
// Each cycle retires ceil(WIDTH/32) quotient bits so the latency does not
// depend on WIDTH.
//   clk, reset   : clock, synchronous active-high reset
//   i_start      : load operands and begin (single-cycle pulse)
//   i_dividend   : signed dividend
//   i_divisor    : signed divisor (non-zero)
//   o_quotient   : signed quotient, held until the next start
//   o_done       : one-cycle strobe, 32 cycles after i_start
module seq_div_s #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_done
);

  localparam int unsigned STEPS = 32;
  localparam int unsigned BPC   = (WIDTH + STEPS - 1) / STEPS;
  localparam int unsigned PW    = STEPS * BPC;

  logic [WIDTH:0]   r_rem, w_rem;
  logic [PW-1:0]    r_quo, w_quo;
  logic [WIDTH-1:0] r_div, w_abs_a, w_abs_b;
  logic             r_neg, r_run, r_done;
  logic [4:0]       r_cnt;

  assign w_abs_a = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_abs_b = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

  // r_quo doubles as the dividend shift register: bits leave at the top,
  // quotient bits enter at the bottom.
  always_comb begin
    w_rem = r_rem;
    w_quo = r_quo;
    for (int i = 0; i < int'(BPC); i++) begin
      w_rem = {w_rem[WIDTH-1:0], w_quo[PW-1]};
      w_quo = {w_quo[PW-2:0], 1'b0};
      if (w_rem >= {1'b0, r_div}) begin
        w_rem    = w_rem - {1'b0, r_div};
        w_quo[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_neg  <= 1'b0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= '0;
        r_quo <= PW'(w_abs_a);
        r_div <= w_abs_b;
        r_neg <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_rem;
        r_quo <= w_quo;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_neg ? -r_quo[WIDTH-1:0] : r_quo[WIDTH-1:0];
  assign o_done     = r_done;

endmodule

// File: rtl/phase_average.sv
// Averages the A-B phase difference and magnitude of the per-packet peak
// record over RUNS packets, with wrap-safe angle arithmetic.
// Optional feature macro: PHASE_AVG_SPREAD_EN adds source_spread
// (max(delta) - min(delta) over the runs).
//   clk, reset            : clock, synchronous active-high reset
//   sink_sop/eop/valid    : packet framing and record qualifier
//   sink_freq/mag         : peak record frequency and magnitude (FP)
//   sink_phaseA/phaseB    : phases of the two channels (FP deg)
//   source_valid          : one-cycle result strobe
//   source_freq/mag/phase : averaged result, held until next strobe
//   busy                  : high in DIV and WRAP
//   protocol_err, drop    : sticky error flags, cleared by reset only
module phase_average
  import phase_pkg::*;
#(
  parameter int unsigned RUNS      = 3,
  parameter int unsigned ACC_WIDTH = 32 + $clog2(RUNS) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic        sink_valid,
  input  logic [31:0] sink_freq,
  input  logic [31:0] sink_mag,
  input  logic [31:0] sink_phaseA,
  input  logic [31:0] sink_phaseB,
  output logic        source_valid,
  output logic [31:0] source_freq,
  output logic [31:0] source_mag,
  output logic [31:0] source_phase,
  output logic        busy,
  output logic        protocol_err,
  output logic        drop
`ifdef PHASE_AVG_SPREAD_EN
  ,
  output logic [31:0] source_spread
`endif
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  state_e     r_state, w_state_next;
  logic [7:0] r_run_cnt;
  fp_t        r_best_mag, r_best_freq, r_best_d, r_ref, r_last_freq;
  acc_t       r_acc_ph, r_acc_mag, w_acc_ph_new, w_acc_mag_new, w_q_ph, w_q_mag;
  logic       r_dropping, r_perr, r_drop, r_src_valid;
  fp_t        r_src_freq, r_src_mag, r_src_phase;
  fp_t        w_cur_mag, w_cur_freq, w_cur_d, w_rec_mag, w_rec_freq, w_rec_d;
  fp_t        w_delta, w_mag_sat;
  logic       w_capture, w_track, w_pkt_end, w_use_cur, w_perr, w_drop_hit;
  logic       w_drop_set, w_drop_clr, w_last_run, w_div_start, w_emit, w_busy;
  logic       w_done_ph, w_done_mag;

  assign w_cur_mag  = sink_mag;
  assign w_cur_freq = sink_freq;
  assign w_cur_d    = wrap_deg({{2{sink_phaseA[31]}}, sink_phaseA}
                             - {{2{sink_phaseB[31]}}, sink_phaseB});

  // The closing record of a packet is either the stored peak or, when it is
  // strictly larger (or opens the packet itself), the current one.
  assign w_rec_mag  = w_use_cur ? w_cur_mag  : r_best_mag;
  assign w_rec_freq = w_use_cur ? w_cur_freq : r_best_freq;
  assign w_rec_d    = w_use_cur ? w_cur_d    : r_best_d;

  // Deltas relative to the first run keep the sum free of 360-degree jumps.
  assign w_delta = (r_run_cnt == 8'd0) ? '0
                 : wrap_deg({{2{w_rec_d[31]}}, w_rec_d} - {{2{r_ref[31]}}, r_ref});

  assign w_acc_ph_new  = r_acc_ph  + ACC_WIDTH'(w_delta);
  assign w_acc_mag_new = r_acc_mag + ACC_WIDTH'(w_rec_mag);
  assign w_last_run    = (r_run_cnt == 8'(RUNS - 1));
  assign w_busy        = (r_state == DIV) || (r_state == WRAP);

  assign w_mag_sat = (w_q_mag[ACC_WIDTH-1:31] == '0 || w_q_mag[ACC_WIDTH-1:31] == '1)
                   ? w_q_mag[31:0]
                   : (w_q_mag[ACC_WIDTH-1] ? 32'h8000_0000 : 32'h7fff_ffff);

  seq_div_s #(.WIDTH(ACC_WIDTH)) u_div_ph (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_acc_ph_new),
    .i_divisor  (ACC_WIDTH'(RUNS)),
    .o_quotient (w_q_ph),
    .o_done     (w_done_ph)
  );

  seq_div_s #(.WIDTH(ACC_WIDTH)) u_div_mag (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_acc_mag_new),
    .i_divisor  (ACC_WIDTH'(RUNS)),
    .o_quotient (w_q_mag),
    .o_done     (w_done_mag)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_track      = 1'b0;
    w_pkt_end    = 1'b0;
    w_use_cur    = 1'b0;
    w_perr       = 1'b0;
    w_drop_hit   = 1'b0;
    w_drop_set   = 1'b0;
    w_drop_clr   = 1'b0;
    w_div_start  = 1'b0;
    w_emit       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (sink_valid && sink_sop) begin
          w_capture  = 1'b1;
          w_drop_clr = 1'b1;
          w_perr     = r_dropping;  // a dropped packet was still open
          if (sink_eop) begin
            w_pkt_end = 1'b1;
            w_use_cur = 1'b1;
          end else begin
            w_state_next = COLLECT;
          end
        end else if (sink_valid && sink_eop) begin
          if (r_dropping) w_drop_clr = 1'b1;
          else            w_perr     = 1'b1;
        end
      end
      COLLECT: begin
        if (sink_valid && sink_sop) begin
          w_capture = 1'b1;
          w_perr    = 1'b1;
          if (sink_eop) begin
            w_pkt_end = 1'b1;
            w_use_cur = 1'b1;
          end
        end else if (sink_valid && sink_eop) begin
          w_pkt_end = 1'b1;
          w_use_cur = w_cur_mag > r_best_mag;
        end else if (sink_valid) begin
          w_track = 1'b1;
        end
      end
      DIV: begin
        if (w_done_ph && w_done_mag) w_state_next = WRAP;
      end
      WRAP: begin
        w_emit       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Packets arriving while busy are swallowed up to their eop.
    if (w_busy && sink_valid) begin
      if (sink_sop) begin
        w_drop_hit = 1'b1;
        if (sink_eop) w_drop_clr = 1'b1;
        else          w_drop_set = 1'b1;
      end else if (sink_eop) begin
        if (r_dropping) w_drop_clr = 1'b1;
        else            w_perr     = 1'b1;
      end
    end
    if (w_pkt_end) begin
      if (w_last_run) begin
        w_div_start  = 1'b1;
        w_state_next = DIV;
      end else begin
        w_state_next = IDLE;
      end
    end
  end

`ifdef PHASE_AVG_SPREAD_EN
  fp_t r_dmin, r_dmax, r_spread;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dmin   <= '0;
      r_dmax   <= '0;
      r_spread <= '0;
    end else begin
      if (w_pkt_end) begin
        if (r_run_cnt == 8'd0) begin
          r_dmin <= '0;
          r_dmax <= '0;
        end else begin
          if (w_delta < r_dmin) r_dmin <= w_delta;
          if (w_delta > r_dmax) r_dmax <= w_delta;
        end
      end
      if (w_emit) r_spread <= r_dmax - r_dmin;
    end
  end

  assign source_spread = r_spread;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt   <= '0;
      r_best_mag  <= '0;
      r_best_freq <= '0;
      r_best_d    <= '0;
      r_ref       <= '0;
      r_last_freq <= '0;
      r_acc_ph    <= '0;
      r_acc_mag   <= '0;
      r_dropping  <= 1'b0;
      r_perr      <= 1'b0;
      r_drop      <= 1'b0;
      r_src_valid <= 1'b0;
      r_src_freq  <= '0;
      r_src_mag   <= '0;
      r_src_phase <= '0;
    end else begin
      r_src_valid <= w_emit;
      // Strict compare: ties keep the earlier record.
      if (w_capture || (w_track && w_cur_mag > r_best_mag)) begin
        r_best_mag  <= w_cur_mag;
        r_best_freq <= w_cur_freq;
        r_best_d    <= w_cur_d;
      end
      if (w_perr)     r_perr <= 1'b1;
      if (w_drop_hit) r_drop <= 1'b1;
      if (w_drop_set)      r_dropping <= 1'b1;
      else if (w_drop_clr) r_dropping <= 1'b0;
      if (w_pkt_end) begin
        r_acc_ph    <= w_acc_ph_new;
        r_acc_mag   <= w_acc_mag_new;
        r_last_freq <= w_rec_freq;
        if (r_run_cnt == 8'd0) r_ref <= w_rec_d;
        if (!w_last_run)       r_run_cnt <= r_run_cnt + 8'd1;
      end
      if (w_emit) begin
        r_src_phase <= wrap_deg({{2{r_ref[31]}}, r_ref} + w_q_ph[33:0]);
        r_src_mag   <= w_mag_sat;
        r_src_freq  <= r_last_freq;
        r_run_cnt   <= '0;
        r_acc_ph    <= '0;
        r_acc_mag   <= '0;
      end
    end
  end

  assign source_valid = r_src_valid;
  assign source_freq  = r_src_freq;
  assign source_mag   = r_src_mag;
  assign source_phase = r_src_phase;
  assign busy         = w_busy;
  assign protocol_err = r_perr;
  assign drop         = r_drop;

endmodule
